// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: default widths, access-size encoding,
// debug-dump FSM states and the size/alignment helpers.
package mem_stage_pkg;

  localparam int NB_PC_DEF   = 32;
  localparam int NB_REG_DEF  = 5;
  localparam int NB_ADDR_DEF = 7;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    DBG_IDLE     = 2'd0,
    DBG_READ     = 2'd1,
    DBG_WAIT_ACK = 2'd2,
    DBG_DONE     = 2'd3
  } dbg_state_e;

  // Anything other than exactly one size enable is handled as a word access.
  function automatic size_e decode_size(input logic byte_en, input logic half_en,
                                        input logic word_en);
    if (byte_en && !half_en && !word_en)      return SIZE_BYTE;
    else if (half_en && !byte_en && !word_en) return SIZE_HALF;
    else                                      return SIZE_WORD;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SIZE_HALF: return lo[0];
      SIZE_WORD: return |lo;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, MEM/WB outputs and the debug-dump handshake of the MEM stage.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int NB_PC   = NB_PC_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
);
  logic              MEM_reg_write;
  logic              MEM_mem_to_reg;
  logic              MEM_mem_read;
  logic              MEM_mem_write;
  logic              MEM_branch;
  logic              MEM_zero;
  logic              MEM_byte_en;
  logic              MEM_halfword_en;
  logic              MEM_word_en;
  logic              MEM_unsigned;
  logic              MEM_r31_ctrl;
  logic [NB_PC-1:0]  MEM_branch_addr;
  logic [NB_PC-1:0]  MEM_alu_result;
  logic [NB_PC-1:0]  MEM_data_a;
  logic [NB_PC-1:0]  MEM_pc;
  logic [NB_REG-1:0] MEM_selected_reg;

  logic              o_pc_src;
  logic [NB_PC-1:0]  o_branch_addr;
  logic [NB_PC-1:0]  o_read_data;
  logic              o_reg_write;
  logic              o_mem_to_reg;
  logic              o_r31_ctrl;
  logic [NB_PC-1:0]  o_alu_result;
  logic [NB_PC-1:0]  o_pc;
  logic [NB_REG-1:0] o_selected_reg;
  logic              o_misaligned;

  logic               i_debug_dump;
  logic               i_debug_ack;
  logic               o_debug_valid;
  logic [NB_ADDR-1:0] o_debug_addr;
  logic [NB_PC-1:0]   o_debug_data;
  logic               o_debug_done;

  modport master (
    output MEM_reg_write, MEM_mem_to_reg, MEM_mem_read, MEM_mem_write, MEM_branch,
           MEM_zero, MEM_byte_en, MEM_halfword_en, MEM_word_en, MEM_unsigned,
           MEM_r31_ctrl, MEM_branch_addr, MEM_alu_result, MEM_data_a, MEM_pc,
           MEM_selected_reg, i_debug_dump, i_debug_ack,
    input  o_pc_src, o_branch_addr, o_read_data, o_reg_write, o_mem_to_reg, o_r31_ctrl,
           o_alu_result, o_pc, o_selected_reg, o_misaligned, o_debug_valid,
           o_debug_addr, o_debug_data, o_debug_done
  );

  modport slave (
    input  MEM_reg_write, MEM_mem_to_reg, MEM_mem_read, MEM_mem_write, MEM_branch,
           MEM_zero, MEM_byte_en, MEM_halfword_en, MEM_word_en, MEM_unsigned,
           MEM_r31_ctrl, MEM_branch_addr, MEM_alu_result, MEM_data_a, MEM_pc,
           MEM_selected_reg, i_debug_dump, i_debug_ack,
    output o_pc_src, o_branch_addr, o_read_data, o_reg_write, o_mem_to_reg, o_r31_ctrl,
           o_alu_result, o_pc, o_selected_reg, o_misaligned, o_debug_valid,
           o_debug_addr, o_debug_data, o_debug_done
  );

endinterface

// File: rtl/mem_stage_data_memory.sv
// Byte-lane data memory: one lane-enabled write port, an asynchronous CPU read
// port and an asynchronous debug read port.
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [NB_DATA/8-1:0] lane_en,
  input  logic [NB_ADDR-1:0]   wr_addr,
  input  logic [NB_DATA-1:0]   wr_data,
  input  logic [NB_ADDR-1:0]   cpu_addr,
  output logic [NB_DATA-1:0]   cpu_data,
  input  logic [NB_ADDR-1:0]   dbg_addr,
  output logic [NB_DATA-1:0]   dbg_data
);

  localparam int NB_LANES = NB_DATA / 8;
  localparam int DEPTH    = 1 << NB_ADDR;

  // One 8-bit array per lane keeps partial writes a plain per-lane enable.
  generate
    for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we && lane_en[gi]) begin
          lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
        end
      end

      assign cpu_data[gi*8 +: 8] = lane_mem[cpu_addr];
      assign dbg_data[gi*8 +: 8] = lane_mem[dbg_addr];
    end
  endgenerate

endmodule

// File: rtl/mem_stage.sv
// MEM stage: sized loads/stores with lane steering and extension, branch
// resolution, MEM/WB passthroughs and a handshaked dump of the data memory.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int NB_PC   = NB_PC_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input logic        i_clock,
  input logic        i_reset,
  mem_stage_if.slave bus
);

  localparam logic [NB_ADDR-1:0] LAST_IDX = '1;

  size_e              size_sel;
  logic [1:0]         byte_off;
  logic [NB_ADDR-1:0] word_idx;
  logic               misaligned;
  logic               store_en;
  logic [3:0]         lane_en;
  logic [NB_PC-1:0]   wr_data;
  logic [NB_PC-1:0]   rd_word;
  logic [NB_PC-1:0]   dbg_rd_word;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [NB_PC-1:0]   load_ext;

  dbg_state_e         state_reg;
  logic [NB_ADDR-1:0] counter_reg;
  logic               dbg_valid_reg;
  logic               dbg_done_reg;
  logic [NB_ADDR-1:0] dbg_addr_reg;
  logic [NB_PC-1:0]   dbg_data_reg;

  assign size_sel   = decode_size(bus.MEM_byte_en, bus.MEM_halfword_en, bus.MEM_word_en);
  assign byte_off   = bus.MEM_alu_result[1:0];
  assign word_idx   = bus.MEM_alu_result[NB_ADDR+1:2];
  assign misaligned = is_misaligned(size_sel, byte_off);

  // Stores freeze while a dump is in flight so the debug unit sees a snapshot.
  assign store_en = bus.MEM_mem_write && !misaligned && (state_reg == DBG_IDLE) && !i_reset;

  always_comb begin
    wr_data = bus.MEM_data_a;
    lane_en = 4'b1111;
    case (size_sel)
      SIZE_BYTE: begin
        wr_data = {4{bus.MEM_data_a[7:0]}};
        lane_en = 4'b0001 << byte_off;
      end
      SIZE_HALF: begin
        wr_data = {2{bus.MEM_data_a[15:0]}};
        lane_en = byte_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  data_memory #(
    .NB_DATA (NB_PC),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .clk      (i_clock),
    .we       (store_en),
    .lane_en  (lane_en),
    .wr_addr  (word_idx),
    .wr_data  (wr_data),
    .cpu_addr (word_idx),
    .cpu_data (rd_word),
    .dbg_addr (counter_reg),
    .dbg_data (dbg_rd_word)
  );

  assign ld_byte = rd_word[{byte_off, 3'b000} +: 8];
  assign ld_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_ext = rd_word;
    case (size_sel)
      SIZE_BYTE: load_ext = {{(NB_PC-8){ld_byte[7] & ~bus.MEM_unsigned}}, ld_byte};
      SIZE_HALF: load_ext = {{(NB_PC-16){ld_half[15] & ~bus.MEM_unsigned}}, ld_half};
      default:   ;
    endcase
  end

  assign bus.o_read_data    = (bus.MEM_mem_read && !misaligned) ? load_ext : '0;
  assign bus.o_misaligned   = (bus.MEM_mem_read | bus.MEM_mem_write) & misaligned;
  assign bus.o_reg_write    = bus.MEM_reg_write & ~(bus.MEM_mem_read & misaligned);
  assign bus.o_pc_src       = bus.MEM_branch & bus.MEM_zero;
  assign bus.o_branch_addr  = bus.MEM_branch_addr;
  assign bus.o_mem_to_reg   = bus.MEM_mem_to_reg;
  assign bus.o_r31_ctrl     = bus.MEM_r31_ctrl;
  assign bus.o_alu_result   = bus.MEM_alu_result;
  assign bus.o_pc           = bus.MEM_pc;
  assign bus.o_selected_reg = bus.MEM_selected_reg;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg     <= DBG_IDLE;
      counter_reg   <= '0;
      dbg_valid_reg <= 1'b0;
      dbg_done_reg  <= 1'b0;
      dbg_addr_reg  <= '0;
      dbg_data_reg  <= '0;
    end else begin
      dbg_done_reg <= 1'b0;
      case (state_reg)
        DBG_IDLE: begin
          if (bus.i_debug_dump) begin
            counter_reg <= '0;
            state_reg   <= DBG_READ;
          end
        end
        DBG_READ: begin
          dbg_data_reg  <= dbg_rd_word;
          dbg_addr_reg  <= counter_reg;
          dbg_valid_reg <= 1'b1;
          state_reg     <= DBG_WAIT_ACK;
        end
        DBG_WAIT_ACK: begin
          if (bus.i_debug_ack) begin
            dbg_valid_reg <= 1'b0;
            if (counter_reg == LAST_IDX) begin
              // Done is raised here so it is high for exactly the DONE cycle.
              dbg_done_reg <= 1'b1;
              state_reg    <= DBG_DONE;
            end else begin
              counter_reg <= counter_reg + 1'b1;
              state_reg   <= DBG_READ;
            end
          end
        end
        DBG_DONE: state_reg <= DBG_IDLE;
        default:  state_reg <= DBG_IDLE;
      endcase
    end
  end

  assign bus.o_debug_valid = dbg_valid_reg;
  assign bus.o_debug_done  = dbg_done_reg;
  assign bus.o_debug_addr  = dbg_addr_reg;
  assign bus.o_debug_data  = dbg_data_reg;

endmodule
